rdback_collector: RTL and testbench

//  Receive side of the read path. Pairs each read strobe issued by the instruction dispatcher

---
 rtl/rdback_collector_pkg.sv | 15 +
 rtl/rdback_collector_if.sv | 33 +++
 rtl/rdback_tag_fifo.sv | 56 +++++
 rtl/rdback_collector.sv | 167 ++++++++++++++++
 tb/tb_rdback_collector.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rdback_collector_pkg.sv
// Shared constants and serializer state encoding for the read-back collector.
package rdback_collector_pkg;

  localparam int RDBACK_BURST_W   = 512;
  localparam int RDBACK_OUT_W     = 32;
  localparam int RDBACK_TAG_DEPTH = 16;
  localparam int RDBACK_TIMEOUT   = 1023;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_LOAD = 2'd1,
    SER_SEND = 2'd2
  } ser_state_t;

endpackage

// File: rtl/rdback_collector_if.sv
// Dispatcher/PHY inputs, host word stream and status of the read-back collector.
interface rdback_collector_if #(
  parameter int BURST_W = 512,
  parameter int OUT_W   = 32,
  parameter int CNT_W   = 5
);
  logic               rd_issue;
  logic               rd_issue_pr;
  logic               dfi_rddata_valid;
  logic [BURST_W-1:0] dfi_rddata;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;
  logic               pr_done;
  logic [CNT_W-1:0]   pending_cnt;
  logic               err_tag_ovf;
  logic               err_unexp;
  logic               err_overrun;
  logic               err_timeout;

  modport slave (
    input  rd_issue, rd_issue_pr, dfi_rddata_valid, dfi_rddata, out_ready,
    output out_valid, out_data, out_last, pr_done, pending_cnt,
    output err_tag_ovf, err_unexp, err_overrun, err_timeout
  );

  modport master (
    output rd_issue, rd_issue_pr, dfi_rddata_valid, dfi_rddata, out_ready,
    input  out_valid, out_data, out_last, pr_done, pending_cnt,
    input  err_tag_ovf, err_unexp, err_overrun, err_timeout
  );
endinterface

// File: rtl/rdback_tag_fifo.sv
// 1-bit outstanding-read tag FIFO; push+pop on an empty FIFO passes the pushed tag straight to head.
module rdback_tag_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        push_dat,
  input  logic        pop,
  output logic        head_dat,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop, bypass;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = empty ? push_dat : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & (~full | pop);
    do_pop   = pop & (~empty | push);
    bypass   = do_push & do_pop & empty;
    if (do_push && !bypass) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop && !bypass) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/rdback_collector.sv
// Pairs read tags with DFI bursts, sinks periodic reads, ping-pong buffers host bursts and serializes them.
// Optional RDBACK_TIMEOUT_EN adds an age counter that retires a stale head tag.
module rdback_collector
  import rdback_collector_pkg::*;
#(
  parameter int BURST_W        = RDBACK_BURST_W,
  parameter int OUT_W          = RDBACK_OUT_W,
  parameter int TAG_DEPTH      = RDBACK_TAG_DEPTH,
  parameter int TIMEOUT_CYCLES = RDBACK_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  rdback_collector_if.slave bus
);
  localparam int WORDS = BURST_W / OUT_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic             tag_full, tag_empty, tag_head, tag_pop;
  logic [CNT_W-1:0] tag_cnt;
  logic             data_pop, to_pop, host_arrive, pr_arrive, wr_free, buf_wr, load;

  logic [BURST_W-1:0] buf_q [2];
  logic [BURST_W-1:0] buf_d [2];
  logic [1:0]         buf_full_q, buf_full_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ser_state_t         state_q, state_d;
  logic [BURST_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d, pr_done_q, pr_done_d;
  logic               ovf_q, ovf_d, unexp_q, unexp_d, overrun_q, overrun_d;

  rdback_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.rd_issue),
    .push_dat (bus.rd_issue_pr),
    .pop      (tag_pop),
    .head_dat (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_cnt)
  );

  // Arriving data owns the head tag; a timeout only retires it when no burst shows up that cycle.
  assign data_pop    = bus.dfi_rddata_valid & (~tag_empty | bus.rd_issue);
  assign tag_pop     = data_pop | to_pop;
  assign host_arrive = data_pop & ~tag_head;
  assign pr_arrive   = data_pop & tag_head;
  assign load        = (state_q == SER_LOAD);
  assign wr_free     = ~buf_full_q[wr_ptr_q] | (load & (rd_ptr_q == wr_ptr_q));
  assign buf_wr      = host_arrive & wr_free;

`ifdef RDBACK_TIMEOUT_EN
  logic [9:0] age_q, age_d;
  logic       err_timeout_q, err_timeout_d;

  assign to_pop = ~tag_empty & ~bus.dfi_rddata_valid & (age_q == 10'(TIMEOUT_CYCLES));

  always_comb begin
    age_d         = (tag_pop || tag_empty) ? 10'd0 : age_q + 10'd1;
    err_timeout_d = err_timeout_q | to_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      age_q         <= age_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout  = ^TIMEOUT_CYCLES;
  assign to_pop          = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    wr_ptr_d   = wr_ptr_q;
    if (load) buf_full_d[rd_ptr_q] = 1'b0;
    if (buf_wr) begin
      buf_d[wr_ptr_q]      = bus.dfi_rddata;
      buf_full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = ~wr_ptr_q;
    end
    pr_done_d = pr_arrive;
    ovf_d     = ovf_q | (bus.rd_issue & tag_full & ~tag_pop);
    unexp_d   = unexp_q | (bus.dfi_rddata_valid & ~data_pop);
    overrun_d = overrun_q | (host_arrive & ~wr_free);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    rd_ptr_d    = rd_ptr_q;
    case (state_q)
      SER_IDLE: if (|buf_full_d) state_d = SER_LOAD;
      SER_LOAD: begin
        shift_d     = buf_q[rd_ptr_q];
        idx_d       = '0;
        out_valid_d = 1'b1;
        rd_ptr_d    = ~rd_ptr_q;
        state_d     = SER_SEND;
      end
      SER_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (idx_q == IDX_W'(WORDS - 1)) begin
            out_valid_d = 1'b0;
            state_d     = (|buf_full_d) ? SER_LOAD : SER_IDLE;
          end else begin
            shift_d = shift_q >> OUT_W;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      buf_full_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      state_q     <= SER_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      pr_done_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unexp_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      pr_done_q   <= pr_done_d;
      ovf_q       <= ovf_d;
      unexp_q     <= unexp_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = shift_q[OUT_W-1:0];
  assign bus.out_last    = out_valid_q & (idx_q == IDX_W'(WORDS - 1));
  assign bus.pr_done     = pr_done_q;
  assign bus.pending_cnt = tag_cnt;
  assign bus.err_tag_ovf = ovf_q;
  assign bus.err_unexp   = unexp_q;
  assign bus.err_overrun = overrun_q;
endmodule

// File: tb/tb_rdback_collector.sv
// Scoreboard bench for rdback_collector: expected host words queued at burst drive time, popped on handshake.
module tb_rdback_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   words_seen = 0;
  int   extra_words = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  rdback_collector_if #(.BURST_W(512), .OUT_W(32), .CNT_W(5)) bus ();

  rdback_collector #(
    .BURST_W(512), .OUT_W(32), .TAG_DEPTH(16), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every accepted word must match the scoreboard head; a stalled word must already equal it.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        extra_words++;
        check_eq("extra_word", extra_words, 0);
      end else if (bus.out_ready) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        words_seen++;
        check_eq("word_data", bus.out_data, e[31:0]);
        check_eq("word_last", bus.out_last, e[32]);
      end else begin
        check_eq("stall_data", bus.out_data, exp_q[0][31:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic pr);
    bus.rd_issue    = 1'b1;
    bus.rd_issue_pr = pr;
    tick(1);
    bus.rd_issue    = 1'b0;
    bus.rd_issue_pr = 1'b0;
  endtask

  task automatic burst(input logic [31:0] base, input bit expect_out);
    for (int k = 0; k < 16; k++) begin
      bus.dfi_rddata[k*32 +: 32] = base + 32'(k);
      if (expect_out) exp_q.push_back({(k == 15), base + 32'(k)});
    end
    bus.dfi_rddata_valid = 1'b1;
    tick(1);
    bus.dfi_rddata_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic check_clean(input string tag);
    check_eq({tag, "_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_pending"}, bus.pending_cnt, 5'd0);
    check_eq({tag, "_errs"}, {bus.err_tag_ovf, bus.err_unexp, bus.err_overrun, bus.err_timeout}, 4'b0);
    check_eq({tag, "_prdone"}, bus.pr_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, first, last;
    bus.rd_issue = 1'b0;
    bus.rd_issue_pr = 1'b0;
    bus.dfi_rddata_valid = 1'b0;
    bus.dfi_rddata = '0;
    bus.out_ready = 1'b0;
    tick(3);
    check_clean("reset");
    rst = 1'b0;
    tick(1);

    // Single host read, first word two cycles after the burst
    bus.out_ready = 1'b1;
    issue(1'b0);
    check_eq("host_pending1", bus.pending_cnt, 5'd1);
    tick(19);
    w0 = words_seen;
    burst(32'h1000_0000, 1'b1);
    check_eq("host_lat1", bus.out_valid, 1'b0);
    check_eq("host_pending0", bus.pending_cnt, 5'd0);
    tick(1);
    check_eq("host_lat2", bus.out_valid, 1'b1);
    check_eq("host_first", bus.out_data, 32'h1000_0000);
    wait_drain(100);
    check_eq("host_words", words_seen - w0, 16);

    // Periodic read is sunk with a single pr_done pulse
    issue(1'b1);
    tick(3);
    burst(32'h2000_0000, 1'b0);
    check_eq("pr_done_hi", bus.pr_done, 1'b1);
    check_eq("pr_pending", bus.pending_cnt, 5'd0);
    tick(1);
    check_eq("pr_done_lo", bus.pr_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("pr_no_valid", bus.out_valid, 1'b0);
      tick(1);
    end

    // Back-pressure: one burst in the shift register, two buffered, the fourth overruns
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0);
    tick(2);
    w0 = words_seen;
    for (int b = 0; b < 4; b++) burst(32'h3000_0000 + 32'(b << 8), (b < 3));
    check_eq("bp_overrun", bus.err_overrun, 1'b1);
    check_eq("bp_pending", bus.pending_cnt, 5'd0);
    tick(5);
    check_eq("bp_held", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    wait_drain(200);
    check_eq("bp_words", words_seen - w0, 48);

    // Ready toggling 1010...: 16 words over 31 cycles
    bus.out_ready = 1'b0;
    issue(1'b0);
    tick(2);
    w0 = words_seen;
    burst(32'h4000_0000, 1'b1);
    tick(1);
    first = -1;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = (i % 2 == 0);
      if (bus.out_valid && bus.out_ready) begin
        if (first < 0) first = i;
        last = i;
      end
      tick(1);
    end
    bus.out_ready = 1'b1;
    wait_drain(50);
    check_eq("tog_words", words_seen - w0, 16);
    check_eq("tog_span", last - first + 1, 31);

    // Tag overflow, then unexpected data
    bus.rd_issue = 1'b1;
    bus.rd_issue_pr = 1'b1;
    tick(17);
    bus.rd_issue = 1'b0;
    bus.rd_issue_pr = 1'b0;
    check_eq("ovf_pending", bus.pending_cnt, 5'd16);
    check_eq("ovf_flag", bus.err_tag_ovf, 1'b1);
    bus.dfi_rddata_valid = 1'b1;
    tick(16);
    bus.dfi_rddata_valid = 1'b0;
    check_eq("ovf_drained", bus.pending_cnt, 5'd0);
    check_eq("unexp_before", bus.err_unexp, 1'b0);
    burst(32'h5000_0000, 1'b0);
    check_eq("unexp_flag", bus.err_unexp, 1'b1);
    check_eq("unexp_pending", bus.pending_cnt, 5'd0);
    tick(3);

    // Reset in the middle of a burst drops everything
    issue(1'b0);
    tick(2);
    burst(32'h6000_0000, 1'b1);
    tick(5);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    check_clean("midrst");
    rst = 1'b0;
    tick(3);
    check_eq("midrst_idle", bus.out_valid, 1'b0);

    // Stale head tag
    issue(1'b0);
    tick(40);
    check_eq("to_early", bus.err_timeout, 1'b0);
    check_eq("to_early_pend", bus.pending_cnt, 5'd1);
    tick(20);
`ifdef RDBACK_TIMEOUT_EN
    check_eq("to_flag", bus.err_timeout, 1'b1);
    check_eq("to_pending", bus.pending_cnt, 5'd0);
    burst(32'h7000_0000, 1'b0);
    check_eq("to_late_unexp", bus.err_unexp, 1'b1);
`else
    check_eq("to_off_flag", bus.err_timeout, 1'b0);
    check_eq("to_off_pend", bus.pending_cnt, 5'd1);
    w0 = words_seen;
    burst(32'h7000_0000, 1'b1);
    wait_drain(50);
    check_eq("to_off_words", words_seen - w0, 16);
`endif
    tick(3);
    check_eq("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
